// File: rtl/timer_irq_ctrl_pkg.sv
// Shared definitions for the timer/interrupt block: register word indices,
// TCON bit positions, IRQ FSM state encoding and the default base address.
package pipeline_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  // Word index (Address[3:2]) of each register in the 16-byte window
  localparam logic [1:0] REG_TH_IDX   = 2'd0;
  localparam logic [1:0] REG_TL_IDX   = 2'd1;
  localparam logic [1:0] REG_TCON_IDX = 2'd2;
  localparam logic [1:0] REG_EXC_IDX  = 2'd3;

  // TCON bit positions
  localparam int TCON_EN     = 0;
  localparam int TCON_IE     = 1;
  localparam int TCON_STATUS = 2;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_PEND    = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// Data-memory bus slice seen by the timer: MEM-stage address/data/strobes
// from the core and combinational read data back.
interface timer_irq_ctrl_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;

  modport master (output Address, WriteData, MemRead, MemWrite, input ReadData);
  modport slave  (input Address, WriteData, MemRead, MemWrite, output ReadData);
endinterface

// File: rtl/timer_irq_ctrl_counter.sv
// timer_counter: TH reload register and TL up-counter. o_wrap flags the cycle
// in which an enabled TL sits at all-ones, i.e. the next edge reloads from TH.
module timer_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic        i_th_we,
  input  logic        i_tl_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic        o_wrap
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic        w_wrap;

  assign w_wrap = i_en && (r_tl == 32'hFFFF_FFFF);

  // TH only changes on a software write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_th <= '0;
    else if (i_th_we) r_th <= i_wdata;
  end

  // TL: software write beats reload, reload beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_tl <= '0;
    else if (i_tl_we) r_tl <= i_wdata;
    else if (w_wrap)  r_tl <= r_th;
    else if (i_en)    r_tl <= r_tl + 32'd1;
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_wrap = w_wrap;

endmodule

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: memory-mapped cycle timer with interrupt request FSM.
// Optional feature macro TIMER_EXC_COUNT_EN adds a saturating exception
// counter at +C; without it +C reads 0 and Exception is ignored.
module timer_irq_ctrl
  import pipeline_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic             clk,
  input  logic             rst_n,
  timer_irq_ctrl_if.slave  bus,
  input  logic             Kernel,
  input  logic             Stall,
  input  logic             Exception,
  output logic             Interrupt
);

  logic        w_sel;
  logic [1:0]  w_idx;
  logic        w_wr;
  logic        w_th_we, w_tl_we, w_tcon_we, w_exc_we;
  logic [31:0] w_th, w_tl, w_exc_cnt, w_rdata;
  logic        w_wrap;
  logic        w_status_rise;
  logic        w_irq_next;
  logic        r_en, r_ie, r_status, r_status_prev;
  logic        r_irq;
  irq_state_t  r_state, w_state_next;
  logic        w_unused;

  assign w_sel     = (bus.Address[31:4] == BASE_ADDR[31:4]);
  assign w_idx     = bus.Address[3:2];
  assign w_wr      = w_sel && bus.MemWrite;
  assign w_th_we   = w_wr && (w_idx == REG_TH_IDX);
  assign w_tl_we   = w_wr && (w_idx == REG_TL_IDX);
  assign w_tcon_we = w_wr && (w_idx == REG_TCON_IDX);
  assign w_exc_we  = w_wr && (w_idx == REG_EXC_IDX);

  timer_counter u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (r_en),
    .i_th_we (w_th_we),
    .i_tl_we (w_tl_we),
    .i_wdata (bus.WriteData),
    .o_th    (w_th),
    .o_tl    (w_tl),
    .o_wrap  (w_wrap)
  );

  // TCON: hardware STATUS set on an IE-enabled wrap outranks a software clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en          <= 1'b0;
      r_ie          <= 1'b0;
      r_status      <= 1'b0;
      r_status_prev <= 1'b0;
    end else begin
      if (w_tcon_we) begin
        r_en <= bus.WriteData[TCON_EN];
        r_ie <= bus.WriteData[TCON_IE];
      end
      if (w_wrap && r_ie)  r_status <= 1'b1;
      else if (w_tcon_we)  r_status <= bus.WriteData[TCON_STATUS];
      r_status_prev <= r_status;
    end
  end

  // A request is only queued on a 0->1 edge of STATUS, so reloads while
  // STATUS is still set never stack up a second interrupt
  assign w_status_rise = r_status && !r_status_prev;

  // IRQ FSM state register plus the registered one-cycle Interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IRQ_IDLE;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_irq   <= w_irq_next;
    end
  end

  // IRQ FSM next-state: clearing IE always drops back to IDLE
  always_comb begin
    w_state_next = r_state;
    if (!r_ie) begin
      w_state_next = IRQ_IDLE;
    end else begin
      case (r_state)
        IRQ_IDLE:    if (w_status_rise)     w_state_next = IRQ_PEND;
        IRQ_PEND:    if (!Kernel && !Stall) w_state_next = IRQ_SERVICE;
        IRQ_SERVICE: if (!r_status)         w_state_next = IRQ_IDLE;
        default:                            w_state_next = IRQ_IDLE;
      endcase
    end
  end

  // IRQ FSM output: request exactly on the PEND -> SERVICE transition
  always_comb begin
    w_irq_next = (r_state == IRQ_PEND) && (w_state_next == IRQ_SERVICE);
  end

  assign Interrupt = r_irq;

`ifdef TIMER_EXC_COUNT_EN
  logic [31:0] r_exc_cnt;

  // Exception counter: software write clears, otherwise saturating increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         r_exc_cnt <= '0;
    else if (w_exc_we)                                  r_exc_cnt <= '0;
    else if (Exception && (r_exc_cnt != 32'hFFFF_FFFF)) r_exc_cnt <= r_exc_cnt + 32'd1;
  end

  assign w_exc_cnt = r_exc_cnt;
  assign w_unused  = ^bus.Address[1:0];
`else
  assign w_exc_cnt = '0;
  assign w_unused  = ^{bus.Address[1:0], Exception, w_exc_we};
`endif

  // Same-cycle read mux; unselected or non-read cycles return 0
  always_comb begin
    w_rdata = '0;
    if (w_sel && bus.MemRead) begin
      case (w_idx)
        REG_TH_IDX:   w_rdata = w_th;
        REG_TL_IDX:   w_rdata = w_tl;
        REG_TCON_IDX: w_rdata = {29'd0, r_status, r_ie, r_en};
        default:      w_rdata = w_exc_cnt;
      endcase
    end
  end

  assign bus.ReadData = w_rdata;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed self-checking bench for timer_irq_ctrl. Honors TIMER_EXC_COUNT_EN.
module tb_timer_irq_ctrl;
  import pipeline_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic Kernel = 1'b0;
  logic Stall = 1'b0;
  logic Exception = 1'b0;
  logic Interrupt;

  timer_irq_ctrl_if bus ();

  timer_irq_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .Kernel    (Kernel),
    .Stall     (Stall),
    .Exception (Exception),
    .Interrupt (Interrupt)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int irq_cnt = 0;
  int irq_double = 0;
  bit irq_prev = 1'b0;

  // Count Interrupt pulses and back-to-back highs, sampled mid-cycle
  always @(negedge clk) begin
    if (Interrupt === 1'b1) begin
      irq_cnt++;
      if (irq_prev) irq_double++;
    end
    irq_prev = (Interrupt === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] d);
    bus.Address   = BASE + {28'd0, idx, 2'b00};
    bus.WriteData = d;
    bus.MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.Address = a;
    bus.MemRead = 1'b1;
    #1;
    d = bus.ReadData;
    bus.MemRead = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    wr(REG_TL_IDX, 32'h0000_1234);
    wr(REG_TH_IDX, 32'h0000_ABCD);
    wr(REG_TCON_IDX, 32'h2);
    rd(BASE + 32'h4, d);
    n_cmp++; if (d !== 32'h0000_1234) begin n_bad++; $display("FAIL reset_preload_tl got=%h exp=%h", d, 32'h1234); end
    rst_n = 1'b0;
    #1;
    rd(BASE + 32'h0, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_th got=%h exp=0", d); end
    rd(BASE + 32'h4, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_tl got=%h exp=0", d); end
    rd(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_tcon got=%h exp=0", d); end
    rd(BASE + 32'hC, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_exc got=%h exp=0", d); end
    n_cmp++; if (Interrupt !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b exp=0", Interrupt); end
    step(1);
    rst_n = 1'b1;
    step(1);
    $display("test_reset done");
  endtask

  task automatic test_periodic();
    logic [31:0] d;
    int base;
    do_reset();
    Kernel = 1'b0; Stall = 1'b0;
    wr(REG_TH_IDX, 32'hFFFF_FFFC);
    wr(REG_TL_IDX, 32'hFFFF_FFFC);
    base = irq_cnt;
    wr(REG_TCON_IDX, 32'h3);
    rd(BASE + 32'h4, d);
    n_cmp++; if (d !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL periodic_en_delay tl got=%h exp=%h", d, 32'hFFFF_FFFC); end
    rd(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL periodic_tcon got=%h exp=3", d); end
    rd(BASE + 32'h7, d);
    n_cmp++; if (d !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL periodic_unaligned got=%h exp=%h", d, 32'hFFFF_FFFC); end
    rd(BASE + 32'h14, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL periodic_unselected got=%h exp=0", d); end
    step(3);
    rd(BASE + 32'h4, d);
    n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL periodic_tl_max got=%h exp=%h", d, 32'hFFFF_FFFF); end
    bus.Address = BASE + 32'h4; bus.MemRead = 1'b0; #1;
    n_cmp++; if (bus.ReadData !== 32'h0) begin n_bad++; $display("FAIL periodic_no_memread got=%h exp=0", bus.ReadData); end
    step(1);
    rd(BASE + 32'h4, d);
    n_cmp++; if (d !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL periodic_reload got=%h exp=%h", d, 32'hFFFF_FFFC); end
    rd(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h7) begin n_bad++; $display("FAIL periodic_status got=%h exp=7", d); end
    n_cmp++; if (Interrupt !== 1'b0) begin n_bad++; $display("FAIL periodic_irq_c0 got=%b exp=0", Interrupt); end
    step(1);
    n_cmp++; if (Interrupt !== 1'b0) begin n_bad++; $display("FAIL periodic_irq_c1 got=%b exp=0", Interrupt); end
    step(1);
    n_cmp++; if (Interrupt !== 1'b1) begin n_bad++; $display("FAIL periodic_irq_c2 got=%b exp=1", Interrupt); end
    step(1);
    n_cmp++; if (Interrupt !== 1'b0) begin n_bad++; $display("FAIL periodic_irq_c3 got=%b exp=0", Interrupt); end
    step(4);
    n_cmp++; if (irq_cnt - base !== 1) begin n_bad++; $display("FAIL periodic_pulse_count got=%0d exp=1", irq_cnt - base); end
    wr(REG_TCON_IDX, 32'h0);
    $display("test_periodic done");
  endtask

  task automatic test_masking();
    logic [31:0] d;
    int base;
    do_reset();
    Kernel = 1'b1; Stall = 1'b0;
    wr(REG_TH_IDX, 32'hFFFF_FFFE);
    wr(REG_TL_IDX, 32'hFFFF_FFFE);
    base = irq_cnt;
    wr(REG_TCON_IDX, 32'h3);
    step(10);
    rd(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h7) begin n_bad++; $display("FAIL mask_status got=%h exp=7", d); end
    n_cmp++; if (irq_cnt - base !== 0) begin n_bad++; $display("FAIL mask_kernel got=%0d exp=0", irq_cnt - base); end
    Kernel = 1'b0; Stall = 1'b1;
    step(3);
    n_cmp++; if (irq_cnt - base !== 0) begin n_bad++; $display("FAIL mask_stall got=%0d exp=0", irq_cnt - base); end
    Stall = 1'b0;
    step(1);
    n_cmp++; if (Interrupt !== 1'b1) begin n_bad++; $display("FAIL mask_release_irq got=%b exp=1", Interrupt); end
    step(4);
    n_cmp++; if (irq_cnt - base !== 1) begin n_bad++; $display("FAIL mask_release_count got=%0d exp=1", irq_cnt - base); end
    $display("test_masking done");
  endtask

  task automatic test_ack();
    logic [31:0] d;
    int base;
    do_reset();
    Kernel = 1'b0; Stall = 1'b0;
    wr(REG_TH_IDX, 32'hFFFF_FFF8);
    wr(REG_TL_IDX, 32'hFFFF_FFFE);
    base = irq_cnt;
    wr(REG_TCON_IDX, 32'h3);
    step(6);
    n_cmp++; if (irq_cnt - base !== 1) begin n_bad++; $display("FAIL ack_first_pulse got=%0d exp=1", irq_cnt - base); end
    wr(REG_TCON_IDX, 32'h3);
    rd(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL ack_status_clear got=%h exp=3", d); end
    rd(BASE + 32'h4, d);
    n_cmp++; if (d !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL ack_tl got=%h exp=%h", d, 32'hFFFF_FFFD); end
    base = irq_cnt;
    step(8);
    n_cmp++; if (irq_cnt - base !== 1) begin n_bad++; $display("FAIL ack_second_pulse got=%0d exp=1", irq_cnt - base); end
    base = irq_cnt;
    step(10);
    n_cmp++; if (irq_cnt - base !== 0) begin n_bad++; $display("FAIL ack_missing_no_pulse got=%0d exp=0", irq_cnt - base); end
    rd(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h7) begin n_bad++; $display("FAIL ack_status_held got=%h exp=7", d); end
    $display("test_ack done");
  endtask

  task automatic test_collision();
    logic [31:0] d;
    do_reset();
    wr(REG_TH_IDX, 32'h0000_0100);
    wr(REG_TL_IDX, 32'hFFFF_FFFD);
    wr(REG_TCON_IDX, 32'h1);
    step(2);
    rd(BASE + 32'h4, d);
    n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL coll_pre_wrap got=%h exp=%h", d, 32'hFFFF_FFFF); end
    wr(REG_TL_IDX, 32'h5);
    rd(BASE + 32'h4, d);
    n_cmp++; if (d !== 32'h5) begin n_bad++; $display("FAIL coll_tl_write_wins got=%h exp=5", d); end
    step(1);
    rd(BASE + 32'h4, d);
    n_cmp++; if (d !== 32'h6) begin n_bad++; $display("FAIL coll_tl_after got=%h exp=6", d); end
    wr(REG_TCON_IDX, 32'h0);
    wr(REG_TL_IDX, 32'hFFFF_FFFD);
    wr(REG_TCON_IDX, 32'h3);
    step(2);
    wr(REG_TCON_IDX, 32'h3);
    rd(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h7) begin n_bad++; $display("FAIL coll_set_wins got=%h exp=7", d); end
    rd(BASE + 32'h4, d);
    n_cmp++; if (d !== 32'h100) begin n_bad++; $display("FAIL coll_reload got=%h exp=100", d); end
    step(1);
    wr(REG_TCON_IDX, 32'h3);
    rd(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL coll_plain_clear got=%h exp=3", d); end
    $display("test_collision done");
  endtask

  task automatic test_exc();
    logic [31:0] d;
    logic [31:0] exp3;
`ifdef TIMER_EXC_COUNT_EN
    exp3 = 32'd3;
`else
    exp3 = 32'd0;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      Exception = 1'b1;
      step(1);
      Exception = 1'b0;
      step(1);
    end
    rd(BASE + 32'hC, d);
    n_cmp++; if (d !== exp3) begin n_bad++; $display("FAIL exc_count got=%h exp=%h", d, exp3); end
    wr(REG_EXC_IDX, 32'h0000_0123);
    rd(BASE + 32'hC, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL exc_clear got=%h exp=0", d); end
    $display("test_exc done");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.Address   = 32'h0;
    bus.WriteData = 32'h0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    step(2);
    test_reset();
    test_periodic();
    test_masking();
    test_ack();
    test_collision();
    test_exc();
    n_cmp++; if (irq_double !== 0) begin n_bad++; $display("FAIL back_to_back_irq got=%0d exp=0", irq_double); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
